// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage core port and a debug/loader port.
// Ports: clk, reset; i_core_* / o_core_* core side; i_dbg_* / o_dbg_* debug side; o_mem_* / i_mem_rdata memory.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [DM_ADDRESS-1:0] i_core_addr,
  input  logic [DATA_W-1:0]     i_core_wdata,
  input  logic [2:0]            i_core_func3,
  output logic                  o_core_stall,
  output logic [DATA_W-1:0]     o_core_rdata,
  output logic                  o_core_rvalid,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [DM_ADDRESS-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0]     i_dbg_wdata,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rvalid,
  output logic [DATA_W-1:0]     o_dbg_rdata,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic [DM_ADDRESS-1:0] o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [2:0]            o_mem_func3,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CORE_RD = 2'd1,
    S_DBG_RD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             w_dbg_force;
  logic             w_core_win;
  logic             w_dbg_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Once the debug port has waited STARVE_MAX cycles it pre-empts the core.
  always_comb begin
    w_dbg_force = i_dbg_req && (r_starve_cnt == CNT_MAX);
    w_core_win  = (r_state == S_IDLE) && i_core_req && !w_dbg_force;
    w_dbg_win   = (r_state == S_IDLE) && !w_core_win && i_dbg_req;
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!i_dbg_req || w_dbg_win) begin
      w_starve_nxt = '0;
    end else if (r_starve_cnt != CNT_MAX) begin
      w_starve_nxt = r_starve_cnt + CNT_W'(1);
    end
  end

  // Outputs are combinational; they are forced to zero while reset is held.
  always_comb begin
    w_state_nxt   = r_state;
    o_core_stall  = 1'b0;
    o_core_rdata  = '0;
    o_core_rvalid = 1'b0;
    o_dbg_gnt     = 1'b0;
    o_dbg_rvalid  = 1'b0;
    o_dbg_rdata   = '0;
    o_mem_rd      = 1'b0;
    o_mem_wr      = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    o_mem_func3   = 3'b000;
    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_core_win) begin
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
            o_mem_func3 = i_core_func3;
            if (i_core_we) begin
              o_mem_wr = 1'b1;
            end else begin
              o_mem_rd     = 1'b1;
              o_core_stall = 1'b1;
              w_state_nxt  = S_CORE_RD;
            end
          end else if (w_dbg_win) begin
            o_dbg_gnt    = 1'b1;
            o_core_stall = i_core_req;
            o_mem_addr   = i_dbg_addr;
            o_mem_wdata  = i_dbg_wdata;
            o_mem_func3  = 3'b010;
            if (i_dbg_we) begin
              o_mem_wr = 1'b1;
            end else begin
              o_mem_rd    = 1'b1;
              w_state_nxt = S_DBG_RD;
            end
          end
        end
        S_CORE_RD: begin
          o_core_rdata  = i_mem_rdata;
          o_core_rvalid = 1'b1;
          w_state_nxt   = S_IDLE;
        end
        S_DBG_RD: begin
          o_dbg_rdata  = i_mem_rdata;
          o_dbg_rvalid = 1'b1;
          o_core_stall = i_core_req;
          w_state_nxt  = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Drives inputs 1 time unit after posedge and checks combinational outputs 1 unit later.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [2:0]    core_func3;
  logic          core_stall;
  logic [DW-1:0] core_rdata;
  logic          core_rvalid;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W(DW), .DM_ADDRESS(AW), .STARVE_MAX(8)
  ) dut (
    .clk(clk), .reset(reset),
    .i_core_req(core_req), .i_core_we(core_we),
    .i_core_addr(core_addr), .i_core_wdata(core_wdata),
    .i_core_func3(core_func3),
    .o_core_stall(core_stall), .o_core_rdata(core_rdata),
    .o_core_rvalid(core_rvalid),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we),
    .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt), .o_dbg_rvalid(dbg_rvalid),
    .o_dbg_rdata(dbg_rdata),
    .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_func3(mem_func3), .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    core_req = 0; core_we = 0; core_addr = '0;
    core_wdata = '0; core_func3 = 3'b000;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0;
    dbg_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    idle_in();
    mem_rdata = '0;
    reset = 1;
    // reset with active requests: everything stays 0
    core_req = 1; core_we = 0; core_addr = 9'h055;
    dbg_req = 1;
    cyc(); cyc(); #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_gnt", dbg_gnt, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_cnt", dut.r_starve_cnt, 0);
    cyc();
    reset = 0; idle_in(); #1;
    chk("idle_addr", mem_addr, 0);
    chk("idle_cmd", {mem_rd, mem_wr}, 0);

    // core store
    cyc();
    core_req = 1; core_we = 1; core_addr = 9'h010;
    core_wdata = 32'hDEADBEEF; core_func3 = 3'b010; #1;
    chk("st_wr", mem_wr, 1);
    chk("st_rd", mem_rd, 0);
    chk("st_addr", mem_addr, 9'h010);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_stall", core_stall, 0);
    chk("st_f3", mem_func3, 3'b010);

    // core load
    cyc();
    core_we = 0; core_addr = 9'h020;
    core_wdata = '0; core_func3 = 3'b100; #1;
    chk("ld0_rd", mem_rd, 1);
    chk("ld0_stall", core_stall, 1);
    chk("ld0_addr", mem_addr, 9'h020);
    chk("ld0_f3", mem_func3, 3'b100);
    cyc();
    mem_rdata = 32'h12345678; #1;
    chk("ld1_rvalid", core_rvalid, 1);
    chk("ld1_rdata", core_rdata, 32'h12345678);
    chk("ld1_stall", core_stall, 0);
    chk("ld1_cmd", {mem_rd, mem_wr}, 0);
    cyc();
    idle_in(); #1;
    chk("ld2_rvalid", core_rvalid, 0);

    // debug load with core idle
    cyc();
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h040; #1;
    chk("dld0_gnt", dbg_gnt, 1);
    chk("dld0_f3", mem_func3, 3'b010);
    chk("dld0_rd", mem_rd, 1);
    chk("dld0_addr", mem_addr, 9'h040);
    cyc();
    dbg_req = 0; mem_rdata = 32'hCAFEF00D; #1;
    chk("dld1_rvalid", dbg_rvalid, 1);
    chk("dld1_rdata", dbg_rdata, 32'hCAFEF00D);
    chk("dld1_gnt", dbg_gnt, 0);
    chk("dld1_cmd", {mem_rd, mem_wr}, 0);
    cyc(); #1;
    chk("dld2_rvalid", dbg_rvalid, 0);

    // core load arriving during DBG_RD
    cyc();
    dbg_req = 1; dbg_addr = 9'h044; #1;
    chk("c37_gnt", dbg_gnt, 1);
    cyc();
    dbg_req = 0; mem_rdata = 32'h0BADF00D;
    core_req = 1; core_we = 0; core_addr = 9'h030;
    core_func3 = 3'b010; #1;
    chk("c37_dvalid", dbg_rvalid, 1);
    chk("c37_stall0", core_stall, 1);
    chk("c37_cmd0", {mem_rd, mem_wr}, 0);
    cyc(); #1;
    chk("c37_rd1", mem_rd, 1);
    chk("c37_addr1", mem_addr, 9'h030);
    chk("c37_stall1", core_stall, 1);
    cyc();
    mem_rdata = 32'hA5A5_5A5A; #1;
    chk("c37_rvalid2", core_rvalid, 1);
    chk("c37_rdata2", core_rdata, 32'hA5A5_5A5A);
    chk("c37_stall2", core_stall, 0);
    cyc();
    idle_in();

    // starvation: debug store vs continuous core stores
    core_req = 1; core_we = 1; core_addr = 9'h100;
    core_wdata = 32'h1111_2222; core_func3 = 3'b010;
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h0AA;
    dbg_wdata = 32'h0000_0055; #1;
    for (int i = 0; i < 8; i++) begin
      chk("sv_cnt", dut.r_starve_cnt, i);
      chk("sv_gnt", dbg_gnt, 0);
      chk("sv_addr", mem_addr, 9'h100);
      chk("sv_wr", mem_wr, 1);
      cyc(); #1;
    end
    chk("sv9_cnt", dut.r_starve_cnt, 8);
    chk("sv9_gnt", dbg_gnt, 1);
    chk("sv9_stall", core_stall, 1);
    chk("sv9_addr", mem_addr, 9'h0AA);
    chk("sv9_wdata", mem_wdata, 32'h55);
    chk("sv9_wr", mem_wr, 1);
    chk("sv9_rd", mem_rd, 0);
    cyc();
    dbg_req = 0; #1;
    chk("sv10_cnt", dut.r_starve_cnt, 0);
    chk("sv10_addr", mem_addr, 9'h100);
    chk("sv10_stall", core_stall, 0);
    cyc();
    idle_in();

    // debug store while idle stays in IDLE
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h1FF;
    dbg_wdata = 32'hFEED_0001; #1;
    chk("dst_gnt", dbg_gnt, 1);
    chk("dst_wr", mem_wr, 1);
    chk("dst_addr", mem_addr, 9'h1FF);
    cyc();
    idle_in(); #1;
    chk("dst_after", {mem_rd, mem_wr, dbg_rvalid}, 0);

    // reset asserted while in CORE_RD
    cyc();
    core_req = 1; core_we = 0; core_addr = 9'h020; #1;
    chk("rcr_rd", mem_rd, 1);
    cyc();
    reset = 1; dbg_req = 1; mem_rdata = 32'hFFFF_FFFF; #1;
    chk("rcr_rvalid_rst", core_rvalid, 0);
    chk("rcr_rdata_rst", core_rdata, 0);
    cyc();
    reset = 0; idle_in(); #1;
    chk("rcr_rvalid", core_rvalid, 0);
    chk("rcr_state", dut.r_state, 0);
    chk("rcr_cnt", dut.r_starve_cnt, 0);
    cyc(); #1;
    chk("rcr_rvalid2", core_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32: data width.
REQ-002 Parameter DM_ADDRESS, default 9: data memory address width.
REQ-003 Parameter STARVE_MAX, default 8: maximum number of cycles the debug port waits while the core holds the memory.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 core_req  in  1  MEM-stage access request (MemRead|MemWrite).
REQ-007 core_we  in  1  1=store, 0=load.
REQ-008 core_addr  in  DM_ADDRESS  MEM-stage byte address.
REQ-009 core_wdata  in  DATA_W  store data.
REQ-010 core_func3  in  3  access size/sign code, passed to memory.
REQ-011 core_stall  out  1  pipeline hold; PC, IF/ID, ID/EX, EX/MEM and MEM/WB freeze while high.
REQ-012 core_rdata  out  DATA_W  load data; core_rvalid  out  1  load data valid.
REQ-013 dbg_req, dbg_we  in  1 each; dbg_addr  in  DM_ADDRESS; dbg_wdata  in  DATA_W: debug/loader port.
REQ-014 dbg_gnt  out  1  one-cycle pulse when a debug access is issued; dbg_rvalid  out  1; dbg_rdata  out  DATA_W.
REQ-015 mem_rd, mem_wr  out  1 each; mem_addr  out  DM_ADDRESS; mem_wdata  out  DATA_W; mem_func3  out  3: single-port memory command.
REQ-016 mem_rdata  in  DATA_W  valid in the cycle after mem_rd=1.

Function
REQ-017 FSM states: IDLE, CORE_RD, DBG_RD.
REQ-018 The arbiter SHALL issue at most one memory command per cycle; mem_rd and mem_wr SHALL never both be 1.
REQ-019 In IDLE, the core SHALL win when core_req=1, unless dbg_req=1 and starve_cnt==STARVE_MAX.
REQ-020 In IDLE with no core win and dbg_req=1, the debug port SHALL win.
REQ-021 Core store win: mem_wr=1 in the same cycle; core_stall=0; state stays IDLE.
REQ-022 Core load win: mem_rd=1 and core_stall=1 in the issue cycle; next state CORE_RD.
REQ-023 In CORE_RD: core_rdata=mem_rdata, core_rvalid=1, core_stall=0, no memory command; next state IDLE.
REQ-024 Debug win: dbg_gnt=1 and mem_func3=3'b010 (word); a store completes the same cycle, a load moves to DBG_RD.
REQ-025 In DBG_RD: dbg_rdata=mem_rdata, dbg_rvalid=1, no memory command; next state IDLE.
REQ-026 core_stall SHALL be 1 in any cycle where core_req=1 and the core access is not completing (debug win, DBG_RD, load issue cycle).
REQ-027 The memory mux SHALL route mem_addr, mem_wdata and mem_func3 from the winning port; when idle, it SHALL drive zeros.
REQ-028 starve_cnt SHALL increment, saturating at STARVE_MAX, on each cycle where dbg_req=1 and the debug port is not issued; it SHALL clear on a debug win or when dbg_req=0.
REQ-029 Requesters SHALL hold their request fields stable until dbg_gnt or core_stall deassertion; the arbiter does not register request fields.
REQ-030 core_rvalid and dbg_rvalid SHALL each be one-cycle pulses.

Reset
REQ-031 While reset=1: state=IDLE, starve_cnt=0, all outputs 0, no memory command.
REQ-032 If reset asserts in CORE_RD or DBG_RD, the pending rvalid SHALL be dropped, and no rvalid pulse SHALL follow after reset release.

Verification
REQ-033 Core store: core_req=1, we=1, addr=0x010, wdata=0xDEADBEEF -> same cycle mem_wr=1, mem_addr=0x010, core_stall=0.
REQ-034 Core load: core_req=1, we=0, addr=0x020; memory returns 0x12345678 -> cycle0 mem_rd=1, stall=1; cycle1 core_rvalid=1, core_rdata=0x12345678, stall=0.
REQ-035 Contention: dbg_req=1 with continuous core stores -> debug issued on cycle 9 (after 8 waits), core_stall=1 in that cycle, starve_cnt returns to 0.
REQ-036 Debug load while core is idle: dbg addr=0x040 -> dbg_gnt=1 and mem_func3=010; next cycle dbg_rvalid=1 and dbg_rdata=mem_rdata.
REQ-037 Core load arrives during DBG_RD -> core_stall=1 for 1 cycle, then the core load issues, with rvalid 2 cycles after the core request.
REQ-038 Reset asserted in CORE_RD -> core_rvalid stays 0, state=IDLE, starve_cnt=0 after reset release.
